// File: rtl/k2_core_p.sv
// K2 accumulator core: parametrised widths, external async-read program memory,
// 4-op ALU with carry/zero flags, conditional jumps, HALT and start/stall control.
module k2_core_p #(
  parameter int unsigned DW   = 8,
  parameter int unsigned PCW  = 8,
  parameter int unsigned IMMW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  output logic [PCW-1:0]    imem_addr,
  input  logic [IMMW+4:0]   imem_data,
  output logic [DW-1:0]     r0,
  output logic              r0_valid,
  output logic              halted
);

  localparam int unsigned IW = IMMW + 5;

  localparam logic [PCW-1:0] PcOne  = PCW'(1);
  localparam logic [DW:0]    SumOne = (DW + 1)'(1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalt
  } state_e;

  typedef enum logic [1:0] {
    DstRa   = 2'b00,
    DstRb   = 2'b01,
    DstR0   = 2'b10,
    DstNone = 2'b11
  } dst_e;

  typedef enum logic [1:0] {
    OpAdd = 2'b00,
    OpSub = 2'b01,
    OpAnd = 2'b10,
    OpXor = 2'b11
  } op_e;

  // Architectural state
  state_e          state_q, state_d;
  logic [PCW-1:0]  pc_q, pc_d;
  logic [DW-1:0]   ra_q, ra_d;
  logic [DW-1:0]   rb_q, rb_d;
  logic [DW-1:0]   r0_q, r0_d;
  logic            carry_q, carry_d;
  logic            zero_q, zero_d;
  logic            r0_valid_q, r0_valid_d;

  // Instruction fields
  logic            ins_j;
  logic            ins_c;
  dst_e            ins_dst;
  logic            ins_sel_imm;
  logic [IMMW-1:0] ins_imm;
  op_e             ins_op;
  logic            ins_halt;

  logic [DW-1:0]   imm_dw;
  logic [PCW-1:0]  imm_pc;

  logic [DW:0]     alu_wide;
  logic [DW-1:0]   alu_res;
  logic            alu_carry;
  logic [DW-1:0]   result;
  logic            take_jump;

  always_comb begin
    ins_j       = imem_data[IW-1];
    ins_c       = imem_data[IW-2];
    ins_dst     = dst_e'(imem_data[IW-3:IW-4]);
    ins_sel_imm = imem_data[IW-5];
    ins_imm     = imem_data[IMMW-1:0];
    ins_op      = op_e'(ins_imm[1:0]);
    ins_halt    = !ins_j && !ins_c && (ins_dst == DstNone) && ins_sel_imm;
  end

  // Zero-extend the immediate into both the data and the PC domains
  always_comb begin
    imm_dw             = '0;
    imm_dw[IMMW-1:0]   = ins_imm;
    imm_pc             = '0;
    imm_pc[IMMW-1:0]   = ins_imm;
  end

  // Subtraction is RA + ~RB + 1 so carry-out doubles as the "no borrow" flag
  always_comb begin
    alu_wide  = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    unique case (ins_op)
      OpAdd: begin
        alu_wide  = {1'b0, ra_q} + {1'b0, rb_q};
        alu_res   = alu_wide[DW-1:0];
        alu_carry = alu_wide[DW];
      end
      OpSub: begin
        alu_wide  = {1'b0, ra_q} + {1'b0, ~rb_q} + SumOne;
        alu_res   = alu_wide[DW-1:0];
        alu_carry = alu_wide[DW];
      end
      OpAnd: begin
        alu_res   = ra_q & rb_q;
        alu_carry = 1'b0;
      end
      OpXor: begin
        alu_res   = ra_q ^ rb_q;
        alu_carry = 1'b0;
      end
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  assign result = ins_sel_imm ? imm_dw : alu_res;

  // Conditions use the flags as they stood before this instruction
  always_comb begin
    take_jump = 1'b0;
    unique case ({ins_j, ins_c})
      2'b00:   take_jump = 1'b0;
      2'b10:   take_jump = 1'b1;
      2'b01:   take_jump = carry_q;
      2'b11:   take_jump = zero_q;
      default: take_jump = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    r0_d       = r0_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    r0_valid_d = 1'b0;

    unique case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          state_d = StRun;
          pc_d    = '0;
        end
      end
      StRun: begin
        if (!stall) begin
          if (ins_halt) begin
            state_d = StHalt;
          end else begin
            unique case (ins_dst)
              DstRa:   ra_d = result;
              DstRb:   rb_d = result;
              DstR0: begin
                r0_d       = ra_q;
                r0_valid_d = 1'b1;
              end
              DstNone: ;
              default: ;
            endcase
            if (!ins_sel_imm && !ins_dst[1]) begin
              carry_d = alu_carry;
              zero_d  = (alu_res == '0);
            end
            pc_d = take_jump ? imm_pc : pc_q + PcOne;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      r0_q       <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      r0_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      r0_q       <= r0_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      r0_valid_q <= r0_valid_d;
    end
  end

  assign imem_addr = pc_q;
  assign r0        = r0_q;
  assign r0_valid  = r0_valid_q;
  assign halted    = (state_q == StHalt);

endmodule
